spi_cfg_master: RTL and testbench

Register-write sequencer that drives the three-wire SPI configuration bus (nCS, COPI, SCLK) of the on-chip SPI peripheral, which holds the output-enable, PWM-enable and PWM duty-cycle registers. It accepts single write commands over a valid/ready handshake and also runs a bulk sequence that rewrites all five configuration registers (addresses 0–4) in order. It sits between the test/control logic and the peripheral's `ui_in[2:0]` pins and paces SCLK slowly enough for the peripheral's two-flop input synchronisers.

---
 rtl/spi_cfg_pkg.sv | 36 +++
 rtl/spi_cfg_tick_gen.sv | 38 +++
 rtl/spi_cfg_master.sv | 205 ++++++++++++++++++++
 tb/tb_spi_cfg_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg
// Shared definitions for the SPI configuration-bus write sequencer:
// frame geometry, the peripheral's configuration register map, the
// sequencer state enum and a helper that assembles a write frame.
package spi_cfg_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 8;
  localparam int NUM_CFG_REGS = 5;
  localparam int BULK_IDX_W   = $clog2(NUM_CFG_REGS);

  // Configuration register map of the attached peripheral
  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_GAP
  } spi_state_e;

  // Write frame: bit15 = 1 (write), bits14:8 = address, bits7:0 = data
  function automatic logic [FRAME_BITS-1:0] make_write_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {1'b1, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_tick_gen.sv
// spi_cfg_tick_gen
// Half-period divider for SCLK pacing. Emits a one-cycle half_tick every
// CLK_DIV clock cycles. Asserting restart reloads the down-counter so the
// next half_tick arrives exactly CLK_DIV cycles after the restart cycle,
// which lets the sequencer time every state from its entry edge.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   restart    in   reload the divider (sequencer state change)
//   half_tick  out  one-cycle pulse when the current half-period expires
module spi_cfg_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_tick
);

  localparam int               CNT_W  = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign half_tick = (cnt == '0);

endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master
// Register-write sequencer for the peripheral's three-wire configuration
// bus. Sends 16-bit write frames MSB first, either from single commands
// (valid/ready) or from a bulk sequence rewriting addresses 0..4.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | bus idle; pick pending bulk frame, else a command
//   ST_SETUP    | nCS low, COPI = bit15, SCLK low for CLK_DIV cycles
//   ST_SHIFT_HI | SCLK high for CLK_DIV cycles (peripheral samples)
//   ST_SHIFT_LO | SCLK low, next bit on COPI; after bit 0 go to GAP
//   ST_GAP      | nCS high for GAP_CYCLES cycles, frame_done at end
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cmd_valid/ready          single-write handshake
//   cmd_addr, cmd_data       command payload, sampled at handshake edge
//   bulk_start, bulk_data    capture 5 bytes and schedule a bulk write
//   busy                     frame in progress or bulk pending
//   frame_done, bulk_done    end-of-frame / end-of-bulk pulses
//   spi_ncs, spi_copi, spi_sclk  bus pins (all registered)
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [DATA_W-1:0]                cmd_data,
  input  logic                             bulk_start,
  input  logic [NUM_CFG_REGS*DATA_W-1:0]   bulk_data,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             bulk_done,
  output logic                             spi_ncs,
  output logic                             spi_copi,
  output logic                             spi_sclk
);

  localparam int                    GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BULK_IDX_W-1:0] BULK_LAST = BULK_IDX_W'(REG_PWM_DUTY);

  spi_state_e state, next_state;

  logic [FRAME_BITS-1:0]                 shreg;
  logic [3:0]                            bit_cnt;
  logic [GAP_W-1:0]                      gap_cnt;
  logic [NUM_CFG_REGS-1:0][DATA_W-1:0]   bulk_shadow;
  logic [BULK_IDX_W-1:0]                 bulk_idx;
  logic                                  bulk_pending;
  // Set while the frame on the wire is the bulk frame for bulk_idx; a
  // restart clears it so that frame's completion does not advance the
  // freshly reset index.
  logic                                  bulk_inflight;

  logic                    half_tick;
  logic                    tick_restart;
  logic                    load_bulk;
  logic                    load_cmd;
  logic                    frame_end;
  logic                    pend_n;
  logic                    infl_n;
  logic [BULK_IDX_W-1:0]   idx_n;
  logic                    bulk_done_n;
  logic                    on_bus;

  spi_cfg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .restart   (tick_restart),
    .half_tick (half_tick)
  );

  always_comb begin
    next_state = state;
    load_bulk  = 1'b0;
    load_cmd   = 1'b0;
    frame_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bulk_pending) begin
          next_state = ST_SETUP;
          load_bulk  = 1'b1;
        end else if (cmd_valid && cmd_ready) begin
          next_state = ST_SETUP;
          load_cmd   = 1'b1;
        end
      end
      ST_SETUP: begin
        if (half_tick) next_state = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (half_tick) next_state = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (half_tick) next_state = (bit_cnt == 4'd0) ? ST_GAP : ST_SHIFT_HI;
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          next_state = ST_IDLE;
          frame_end  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    tick_restart = (next_state != state);
  end

  // Bulk bookkeeping; a new bulk_start always wins over frame completion.
  always_comb begin
    pend_n      = bulk_pending;
    infl_n      = bulk_inflight;
    idx_n       = bulk_idx;
    bulk_done_n = 1'b0;
    if (load_bulk) infl_n = 1'b1;
    if (frame_end && bulk_inflight) begin
      infl_n = 1'b0;
      if (bulk_idx == BULK_LAST) begin
        pend_n      = 1'b0;
        bulk_done_n = 1'b1;
      end else begin
        idx_n = bulk_idx + BULK_IDX_W'(1);
      end
    end
    if (bulk_start) begin
      pend_n      = 1'b1;
      infl_n      = 1'b0;
      idx_n       = BULK_IDX_W'(REG_EN_OUT_7_0);
      bulk_done_n = 1'b0;
    end
  end

  assign on_bus = (state == ST_SETUP) || (state == ST_SHIFT_HI) || (state == ST_SHIFT_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      bit_cnt       <= 4'd0;
      gap_cnt       <= '0;
      bulk_shadow   <= '0;
      bulk_idx      <= '0;
      bulk_pending  <= 1'b0;
      bulk_inflight <= 1'b0;
    end else begin
      state         <= next_state;
      bulk_pending  <= pend_n;
      bulk_inflight <= infl_n;
      bulk_idx      <= idx_n;
      if (bulk_start) bulk_shadow <= bulk_data;

      if (load_bulk) begin
        shreg   <= make_write_frame(ADDR_W'(bulk_idx), bulk_shadow[bulk_idx]);
        bit_cnt <= 4'd15;
      end else if (load_cmd) begin
        shreg   <= make_write_frame(cmd_addr, cmd_data);
        bit_cnt <= 4'd15;
      end else begin
        if (state == ST_SHIFT_HI && half_tick) begin
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
        if (state == ST_SHIFT_LO && half_tick && bit_cnt != 4'd0) begin
          bit_cnt <= bit_cnt - 4'd1;
        end
      end

      if (next_state == ST_GAP && state != ST_GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Pin outputs follow the state one cycle later, so the handshake edge is
  // followed by nCS falling on the next edge. cmd_ready/busy track the
  // next state so the handshake is decided by registered values only.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_ncs    <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_copi   <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bulk_done  <= 1'b0;
    end else begin
      spi_ncs    <= !on_bus;
      spi_sclk   <= (state == ST_SHIFT_HI);
      spi_copi   <= on_bus ? shreg[FRAME_BITS-1] : 1'b0;
      cmd_ready  <= (next_state == ST_IDLE) && !pend_n;
      busy       <= (next_state != ST_IDLE) || pend_n;
      frame_done <= frame_end;
      bulk_done  <= bulk_done_n;
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  localparam int CD      = 4;
  localparam int GAP     = 8;
  localparam int NCS_LOW = 33 * CD;
  localparam int PERIOD  = 33 * CD + GAP + 1;
  localparam int F_PERIOD = 33 * 2 + 1 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        cmd_valid, cmd_ready, bulk_start, busy, frame_done, bulk_done;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic [39:0] bulk_data;
  logic        spi_ncs, spi_copi, spi_sclk;

  logic        f_cmd_valid, f_cmd_ready, f_bulk_start, f_busy, f_frame_done, f_bulk_done;
  logic [6:0]  f_cmd_addr;
  logic [7:0]  f_cmd_data;
  logic [39:0] f_bulk_data;
  logic        f_ncs, f_copi, f_sclk;

  spi_cfg_master #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bulk_start(bulk_start),
    .bulk_data(bulk_data), .busy(busy), .frame_done(frame_done),
    .bulk_done(bulk_done), .spi_ncs(spi_ncs), .spi_copi(spi_copi),
    .spi_sclk(spi_sclk)
  );

  spi_cfg_master #(.CLK_DIV(2), .GAP_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_addr(f_cmd_addr), .cmd_data(f_cmd_data), .bulk_start(f_bulk_start),
    .bulk_data(f_bulk_data), .busy(f_busy), .frame_done(f_frame_done),
    .bulk_done(f_bulk_done), .spi_ncs(f_ncs), .spi_copi(f_copi),
    .spi_sclk(f_sclk)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name, input int limit);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles (cycle %0d)", name, limit, cyc);
  endtask

  // ---------------- bus monitor / peripheral model ----------------
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  int          last_chg = 0, bits = 0, low_len = 0, start_c = 0;
  logic [15:0] shf = '0;
  logic [15:0] mon_frames[$];
  int          mon_len[$], mon_start[$], fd_q[$], bd_q[$];
  int          aborted = 0, setup_viol = 0, sclk_idle_viol = 0, bd_orphan = 0, f_fd_cnt = 0;
  logic [7:0]  periph[0:4];

  always @(negedge clk) begin
    if (spi_copi !== prev_copi) last_chg = cyc;
    if (spi_ncs === 1'b0) begin
      if (prev_ncs === 1'b1) begin
        bits = 0; shf = '0; low_len = 0; start_c = cyc;
      end
      low_len++;
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (cyc - last_chg < CD) setup_viol++;
        shf = {shf[14:0], spi_copi};
        bits++;
      end
    end else begin
      if (spi_sclk === 1'b1) sclk_idle_viol++;
      if (prev_ncs === 1'b0) begin
        if (bits == 16) begin
          mon_frames.push_back(shf);
          mon_len.push_back(low_len);
          mon_start.push_back(start_c);
          if (shf[14:8] < 7'd5) periph[shf[10:8]] = shf[7:0];
        end else begin
          aborted++;
        end
      end
    end
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (bulk_done === 1'b1) begin
      bd_q.push_back(cyc);
      if (frame_done !== 1'b1) bd_orphan++;
    end
    if (f_frame_done === 1'b1) f_fd_cnt++;
    prev_ncs  = spi_ncs;
    prev_sclk = spi_sclk;
    prev_copi = spi_copi;
  end

  task automatic clear_mon();
    mon_frames.delete(); mon_len.delete(); mon_start.delete();
    fd_q.delete(); bd_q.delete();
    aborted = 0; f_fd_cnt = 0;
  endtask

  function automatic logic [15:0] wr_frame(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit fast, input logic v, input logic [6:0] a, input logic [7:0] d);
    if (fast) begin f_cmd_valid = v; f_cmd_addr = a; f_cmd_data = d; end
    else begin cmd_valid = v; cmd_addr = a; cmd_data = d; end
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic [7:0] d, output int hs);
    int n = 0;
    hs = 0;
    @(negedge clk);
    drive(0, 1'b1, a, d);
    while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout_fail("cmd handshake", 2000);
    hs = cyc + 1;
    @(negedge clk);
    drive(0, 1'b0, 7'($urandom), 8'($urandom));
  endtask

  task automatic pulse_bulk(input logic [39:0] d, output int edge_c);
    @(negedge clk);
    bulk_data = d; bulk_start = 1'b1; edge_c = cyc + 1;
    @(negedge clk);
    bulk_start = 1'b0; bulk_data = {8'($urandom), 32'($urandom)};
  endtask

  task automatic wait_idle(input bit fast, input int limit, input string name);
    int n = 0;
    while ((fast ? f_busy : busy) !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) timeout_fail(name, limit);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frames(input string name, input logic [15:0] exp[$]);
    chk({name, " frame count"}, mon_frames.size(), exp.size());
    for (int i = 0; i < exp.size() && i < mon_frames.size(); i++)
      chk($sformatf("%s frame %0d", name, i), mon_frames[i], exp[i]);
  endtask

  task automatic backpressure(input bit fast, input int period, input string name);
    int hs[$];
    int k = 0, n = 0;
    logic r;
    logic [6:0] a[3];
    logic [7:0] d[3];
    logic [15:0] exp[$];
    for (int i = 0; i < 3; i++) begin
      a[i] = 7'($urandom_range(0, 127)); d[i] = 8'($urandom);
      exp.push_back(wr_frame(a[i], d[i]));
    end
    clear_mon();
    @(negedge clk);
    drive(fast, 1'b1, a[0], d[0]);
    while (k < 3 && n < 1000) begin
      r = fast ? f_cmd_ready : cmd_ready;
      if (r === 1'b1) begin hs.push_back(cyc + 1); k++; end
      @(negedge clk); n++;
      if (r === 1'b1) begin
        if (k < 3) drive(fast, 1'b1, a[k], d[k]);
        else drive(fast, 1'b0, 7'($urandom), 8'($urandom));
      end
    end
    if (k < 3) begin
      timeout_fail({name, " handshakes"}, 1000);
      drive(fast, 1'b0, 7'd0, 8'd0);
    end else begin
      chk({name, " spacing 0-1"}, hs[1] - hs[0], period);
      chk({name, " spacing 1-2"}, hs[2] - hs[1], period);
    end
    wait_idle(fast, 1000, {name, " idle"});
    if (fast) chk({name, " frame_done count"}, f_fd_cnt, 3);
    else check_frames(name, exp);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int hs, bs, bs2;
    logic [39:0] da, db;
    logic [15:0] exp[$];
    logic [7:0]  exp_regs[0:4];
    int exp_bd;

    vecs[0] = '{addr: 7'd4,   data: 8'hA5, frame: 16'h84A5};
    vecs[1] = '{addr: 7'd0,   data: 8'h00, frame: 16'h8000};
    vecs[2] = '{addr: 7'd127, data: 8'hFF, frame: 16'hFFFF};
    vecs[3] = '{addr: 7'd1,   data: 8'h0F, frame: 16'h810F};
    vecs[4] = '{addr: 7'd5,   data: 8'h3C, frame: 16'h853C};
    vecs[5] = '{addr: 7'd2,   data: 8'h80, frame: 16'h8280};
    vecs[6] = '{addr: 7'h55,  data: 8'hAA, frame: 16'hD5AA};

    cmd_valid = 0; cmd_addr = 0; cmd_data = 0; bulk_start = 0; bulk_data = 0;
    f_cmd_valid = 0; f_cmd_addr = 0; f_cmd_data = 0; f_bulk_start = 0; f_bulk_data = 0;
    for (int i = 0; i < 5; i++) periph[i] = 8'h00;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("reset spi_ncs", spi_ncs, 1'b1);
    chk("reset spi_sclk", spi_sclk, 1'b0);
    chk("reset spi_copi", spi_copi, 1'b0);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset frame_done", frame_done, 1'b0);
    chk("reset bulk_done", bulk_done, 1'b0);

    // Single writes from the vector table
    foreach (vecs[i]) begin
      clear_mon();
      send_cmd(vecs[i].addr, vecs[i].data, hs);
      wait_idle(0, 500, "single idle");
      chk($sformatf("single[%0d] count", i), mon_frames.size(), 1);
      chk($sformatf("single[%0d] fd count", i), fd_q.size(), 1);
      if (mon_frames.size() > 0) begin
        chk($sformatf("single[%0d] frame", i), mon_frames[0], vecs[i].frame);
        chk($sformatf("single[%0d] ncs low cycles", i), mon_len[0], NCS_LOW);
        chk($sformatf("single[%0d] ncs fall latency", i), mon_start[0] - hs, 1);
      end
      // handshake edge through the frame_done cycle spans PERIOD cycles
      if (fd_q.size() > 0)
        chk($sformatf("single[%0d] frame_done cycle", i), fd_q[0] - hs + 1, PERIOD);
    end

    // Bulk end-to-end
    clear_mon();
    pulse_bulk(40'h44_33_22_11_FF, bs);
    wait_idle(0, 1000, "bulk idle");
    exp.delete();
    exp.push_back(16'h80FF); exp.push_back(16'h8111); exp.push_back(16'h8222);
    exp.push_back(16'h8333); exp.push_back(16'h8444);
    check_frames("bulk", exp);
    chk("bulk reg en_out_7_0", periph[REG_EN_OUT_7_0], 8'hFF);
    chk("bulk reg en_out_15_8", periph[REG_EN_OUT_15_8], 8'h11);
    chk("bulk reg en_pwm_7_0", periph[REG_EN_PWM_7_0], 8'h22);
    chk("bulk reg en_pwm_15_8", periph[REG_EN_PWM_15_8], 8'h33);
    chk("bulk reg pwm_duty", periph[REG_PWM_DUTY], 8'h44);
    chk("bulk bulk_done count", bd_q.size(), 1);
    if (bd_q.size() > 0) chk("bulk latency", bd_q[0] - bs, 5 * PERIOD);

    // Simultaneous cmd_valid and bulk_start
    clear_mon();
    da = {8'($urandom), 32'($urandom)};
    @(negedge clk);
    chk("simul ready before", cmd_ready, 1'b1);
    cmd_valid = 1; cmd_addr = 7'd1; cmd_data = 8'h0F; bulk_start = 1; bulk_data = da;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 7'h7F; cmd_data = 8'h00; bulk_start = 0; bulk_data = '0;
    wait_idle(0, 2000, "simul idle");
    exp.delete();
    exp.push_back(16'h810F);
    for (int k = 0; k < 5; k++) exp.push_back(wr_frame(7'(k), da[8*k +: 8]));
    check_frames("simul", exp);
    chk("simul bulk_done count", bd_q.size(), 1);

    // Bulk restart during the address-2 frame
    clear_mon();
    da = {8'($urandom), 32'($urandom)};
    db = {8'($urandom), 32'($urandom)};
    pulse_bulk(da, bs);
    begin
      int n = 0;
      while (!(mon_frames.size() == 2 && spi_ncs === 1'b0) && n < 1000) begin
        @(negedge clk); n++;
      end
      if (n >= 1000) timeout_fail("restart reach frame 2", 1000);
    end
    repeat (30) @(negedge clk);
    pulse_bulk(db, bs2);
    wait_idle(0, 2500, "restart idle");
    exp.delete();
    for (int k = 0; k < 3; k++) exp.push_back(wr_frame(7'(k), da[8*k +: 8]));
    for (int k = 0; k < 5; k++) exp.push_back(wr_frame(7'(k), db[8*k +: 8]));
    check_frames("restart", exp);
    chk("restart bulk_done count", bd_q.size(), 1);
    chk("restart frame_done count", fd_q.size(), 8);

    // Back-pressure, default and fast parameters
    backpressure(0, PERIOD, "bp default");
    backpressure(1, F_PERIOD, "bp fast");

    // Reset mid-frame
    clear_mon();
    send_cmd(7'd3, 8'h5A, hs);
    repeat (60) @(negedge clk);
    chk("midreset ncs low before", spi_ncs, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset ncs next edge", spi_ncs, 1'b1);
    chk("midreset sclk next edge", spi_sclk, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset ncs after", spi_ncs, 1'b1);
    chk("midreset sclk after", spi_sclk, 1'b0);
    chk("midreset cmd_ready after", cmd_ready, 1'b1);
    chk("midreset busy after", busy, 1'b0);
    repeat (200) @(negedge clk);
    chk("midreset frame_done count", fd_q.size(), 0);
    chk("midreset aborted frames", aborted, 1);
    chk("midreset complete frames", mon_frames.size(), 0);

    // Randomized traffic against a frame-list reference model
    clear_mon();
    exp.delete();
    exp_bd = 0;
    for (int i = 0; i < 5; i++) exp_regs[i] = periph[i];
    for (int op = 0; op < 6; op++) begin
      if ($urandom_range(0, 2) == 0) begin
        da = {8'($urandom), 32'($urandom)};
        pulse_bulk(da, bs);
        for (int k = 0; k < 5; k++) begin
          exp.push_back(wr_frame(7'(k), da[8*k +: 8]));
          exp_regs[k] = da[8*k +: 8];
        end
        exp_bd++;
        wait_idle(0, 1000, "random bulk idle");
      end else begin
        logic [6:0] a;
        logic [7:0] d;
        a = 7'($urandom_range(0, 127));
        d = 8'($urandom);
        send_cmd(a, d, hs);
        exp.push_back(wr_frame(a, d));
        if (a < 7'd5) exp_regs[a[2:0]] = d;
        wait_idle(0, 500, "random cmd idle");
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    check_frames("random", exp);
    for (int i = 0; i < 5; i++) chk($sformatf("random reg %0d", i), periph[i], exp_regs[i]);
    chk("random bulk_done count", bd_q.size(), exp_bd);

    // Whole-run bus rules
    chk("copi setup before sclk rise", setup_viol, 0);
    chk("sclk high while ncs high", sclk_idle_viol, 0);
    chk("bulk_done without frame_done", bd_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
